// File: rtl/a2d_conv_sched_if.sv
// Signal bundle between the A2D conversion scheduler (master) and the
// balance-control / A2D SPI side (slave).
interface a2d_conv_sched_if #(
  parameter int PER_W = 16,
  parameter int ERR_W = 8
);
  logic             en;
  logic [PER_W-1:0] period;
  logic             conv_done;
  logic             err_clr;
  logic             nxt;
  logic             busy;
  logic [1:0]       ch_idx;
  logic             frame_vld;
  logic             timeout_err;
  logic             overrun;
  logic [ERR_W-1:0] tmo_cnt;

  modport master (
    input  en, period, conv_done, err_clr,
    output nxt, busy, ch_idx, frame_vld, timeout_err, overrun, tmo_cnt
  );

  modport slave (
    output en, period, conv_done, err_clr,
    input  nxt, busy, ch_idx, frame_vld, timeout_err, overrun, tmo_cnt
  );
endinterface

// File: rtl/a2d_conv_sched.sv
// Paces A2D conversions: periodic nxt strobes, 4-channel round-robin index,
// per-conversion watchdog, overrun detection and frame-complete strobe.
module a2d_conv_sched #(
  parameter int PER_W   = 16,
  parameter int TMO_CYC = 4096,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  a2d_conv_sched_if.master bus
);

  localparam int WD_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [WD_W-1:0] TMO_LAST = WD_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    BUSY  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [PER_W-1:0] cnt_r;
  logic             pending_r;
  logic [WD_W-1:0]  wd_r;
  logic [1:0]       ch_idx_r;
  logic             timeout_err_r;
  logic             overrun_r;
  logic [ERR_W-1:0] tmo_cnt_r;

  logic tick_s, busy_tick_s, issue_s, done_s, tmo_s;

  assign tick_s      = (state_r != IDLE) && (cnt_r == {PER_W{1'b0}});
  assign busy_tick_s = tick_s && ((state_r == ISSUE) || (state_r == BUSY));

  // Next-state decode; conv_done has priority over the watchdog expiring.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    done_s  = 1'b0;
    tmo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.en) state_s = WAIT;
        else        state_s = IDLE;
      end
      WAIT: begin
        if (!bus.en) begin
          state_s = IDLE;
        end else if (tick_s || pending_r) begin
          state_s = ISSUE;
          issue_s = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      ISSUE: state_s = BUSY;
      BUSY: begin
        if (bus.conv_done) begin
          done_s  = 1'b1;
          state_s = bus.en ? WAIT : IDLE;
        end else if (wd_r == TMO_LAST) begin
          tmo_s   = 1'b1;
          state_s = bus.en ? WAIT : IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, period counter, watchdog, channel index and error bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= {PER_W{1'b0}};
      pending_r     <= 1'b0;
      wd_r          <= {WD_W{1'b0}};
      ch_idx_r      <= 2'd0;
      timeout_err_r <= 1'b0;
      overrun_r     <= 1'b0;
      tmo_cnt_r     <= {ERR_W{1'b0}};
    end else begin
      state_r <= state_s;

      if (state_r == IDLE) begin
        if (bus.en) cnt_r <= bus.period;
      end else if (tick_s) begin
        cnt_r <= bus.period;
      end else begin
        cnt_r <= cnt_r - PER_W'(1'b1);
      end

      // Ticks landing while a conversion is outstanding collapse into one pending request.
      if ((state_r == IDLE) || issue_s) pending_r <= 1'b0;
      else if (busy_tick_s)             pending_r <= 1'b1;

      if (state_r == ISSUE)     wd_r <= {WD_W{1'b0}};
      else if (state_r == BUSY) wd_r <= wd_r + WD_W'(1'b1);

      if (done_s) ch_idx_r <= ch_idx_r + 2'd1;

      if (tmo_s)            timeout_err_r <= 1'b1;
      else if (bus.err_clr) timeout_err_r <= 1'b0;

      if (busy_tick_s)      overrun_r <= 1'b1;
      else if (bus.err_clr) overrun_r <= 1'b0;

      if (tmo_s && (tmo_cnt_r != {ERR_W{1'b1}})) tmo_cnt_r <= tmo_cnt_r + ERR_W'(1'b1);
    end
  end

  assign bus.nxt         = (state_r == ISSUE);
  assign bus.busy        = (state_r == ISSUE) || (state_r == BUSY);
  assign bus.frame_vld   = done_s && (ch_idx_r == 2'd3);
  assign bus.ch_idx      = ch_idx_r;
  assign bus.timeout_err = timeout_err_r;
  assign bus.overrun     = overrun_r;
  assign bus.tmo_cnt     = tmo_cnt_r;

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Directed self-checking bench for a2d_conv_sched (TMO_CYC reduced to 64).
module tb_a2d_conv_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   nxt_cnt = 0;
  int   fv_cnt  = 0;
  int   dbl_cnt = 0;
  logic prev_nxt = 1'b0;

  a2d_conv_sched_if #(.PER_W(16), .ERR_W(8)) bus ();

  a2d_conv_sched #(.PER_W(16), .TMO_CYC(64), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Strobe monitor sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.nxt) nxt_cnt <= nxt_cnt + 1;
    if (bus.frame_vld) fv_cnt <= fv_cnt + 1;
    if (bus.nxt && prev_nxt) dbl_cnt <= dbl_cnt + 1;
    prev_nxt <= bus.nxt;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_nxt(input string tag, input int max_cyc);
    int n;
    n = 0;
    do begin
      tk();
      n++;
    end while (!bus.nxt && n < max_cyc);
    check_val({tag, "_nxt_seen"}, int'(bus.nxt), 1);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.conv_done = 1'b0;
    bus.err_clr   = 1'b0;
    tk();
    tk();
    rst = 1'b0;
  endtask

  initial begin
    int t0, tn, snap;
    bus.en        = 1'b0;
    bus.period    = 16'd10;
    bus.conv_done = 1'b0;
    bus.err_clr   = 1'b0;

    // Reset state
    do_reset();
    check_val("rst_nxt",     int'(bus.nxt),         0);
    check_val("rst_busy",    int'(bus.busy),        0);
    check_val("rst_ch_idx",  int'(bus.ch_idx),      0);
    check_val("rst_fv",      int'(bus.frame_vld),   0);
    check_val("rst_tmo_err", int'(bus.timeout_err), 0);
    check_val("rst_overrun", int'(bus.overrun),     0);
    check_val("rst_tmo_cnt", int'(bus.tmo_cnt),     0);

    // 1: period=10, done 5 cycles after nxt -> nxt at 12, then every 11
    bus.period = 16'd10;
    bus.en = 1'b1;
    t0 = cyc;
    snap = fv_cnt;
    wait_nxt("t1_first", 40);
    check_val("t1_first_lat", cyc - t0, 12);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("t1_ch%0d", i), int'(bus.ch_idx), i % 4);
      check_val($sformatf("t1_busy%0d", i), int'(bus.busy), 1);
      tn = cyc;
      repeat (5) tk();
      bus.conv_done = 1'b1;
      #1;
      check_val($sformatf("t1_fv%0d", i), int'(bus.frame_vld), (i == 3) ? 1 : 0);
      tk();
      bus.conv_done = 1'b0;
      if (i < 4) begin
        wait_nxt("t1_next", 40);
        check_val($sformatf("t1_period%0d", i), cyc - tn, 11);
      end
    end
    check_val("t1_overrun", int'(bus.overrun), 0);
    check_val("t1_fv_count", fv_cnt - snap, 1);

    // 2: period=4, done 20 cycles after nxt -> overrun, pending reissue 2 cycles after done
    do_reset();
    bus.period = 16'd4;
    bus.en = 1'b1;
    t0 = cyc;
    snap = nxt_cnt;
    wait_nxt("t2_first", 40);
    check_val("t2_first_lat", cyc - t0, 6);
    tn = cyc;
    repeat (20) tk();
    check_val("t2_overrun", int'(bus.overrun), 1);
    bus.conv_done = 1'b1;
    tk();
    bus.conv_done = 1'b0;
    check_val("t2_wait_nxt", int'(bus.nxt), 0);
    check_val("t2_ch_idx", int'(bus.ch_idx), 1);
    tk();
    check_val("t2_reissue", int'(bus.nxt), 1);
    check_val("t2_reissue_at", cyc - tn, 22);
    tk();
    check_val("t2_no_double", int'(bus.nxt), 0);
    check_val("t2_nxt_count", nxt_cnt - snap, 2);

    // 3: never send done -> timeout at nxt+64, retried channel, saturating count
    do_reset();
    bus.period = 16'd4;
    bus.en = 1'b1;
    wait_nxt("t3_first", 40);
    tn = cyc;
    repeat (64) tk();
    check_val("t3_tmo_early", int'(bus.timeout_err), 0);
    tk();
    check_val("t3_tmo_err", int'(bus.timeout_err), 1);
    check_val("t3_tmo_cnt1", int'(bus.tmo_cnt), 1);
    check_val("t3_ch_same", int'(bus.ch_idx), 0);
    wait_nxt("t3_retry", 200);
    check_val("t3_retry_at", cyc - tn, 66);
    for (int k = 0; k < 299; k++) begin
      tk();
      wait_nxt("t3_loop", 200);
    end
    check_val("t3_tmo_sat", int'(bus.tmo_cnt), 255);
    check_val("t3_ch_final", int'(bus.ch_idx), 0);

    // 6a: err_clr coincident with timeout -> flag stays; err_clr alone -> clears
    bus.err_clr = 1'b1;
    tk();
    bus.err_clr = 1'b0;
    check_val("t6_clr", int'(bus.timeout_err), 0);
    repeat (63) tk();
    bus.err_clr = 1'b1;
    tk();
    bus.err_clr = 1'b0;
    check_val("t6_set_wins", int'(bus.timeout_err), 1);
    bus.err_clr = 1'b1;
    tk();
    bus.err_clr = 1'b0;
    check_val("t6_clr_alone", int'(bus.timeout_err), 0);

    // 6b: done coincident with watchdog expiry -> no error, index advances
    do_reset();
    bus.period = 16'd4;
    bus.en = 1'b1;
    wait_nxt("t6b_first", 40);
    repeat (64) tk();
    bus.conv_done = 1'b1;
    tk();
    bus.conv_done = 1'b0;
    check_val("t6b_no_err", int'(bus.timeout_err), 0);
    check_val("t6b_tmo_cnt", int'(bus.tmo_cnt), 0);
    check_val("t6b_ch_adv", int'(bus.ch_idx), 1);

    // 4: drop en mid-conversion -> completes, goes idle, no more nxt
    do_reset();
    bus.period = 16'd10;
    bus.en = 1'b1;
    wait_nxt("t4_first", 40);
    tk();
    tk();
    bus.en = 1'b0;
    repeat (3) tk();
    bus.conv_done = 1'b1;
    tk();
    bus.conv_done = 1'b0;
    check_val("t4_ch_adv", int'(bus.ch_idx), 1);
    check_val("t4_idle", int'(bus.busy), 0);
    snap = nxt_cnt;
    bus.conv_done = 1'b1;
    tk();
    bus.conv_done = 1'b0;
    check_val("t4_idle_done_ign", int'(bus.ch_idx), 1);
    repeat (100) tk();
    check_val("t4_no_nxt", nxt_cnt - snap, 0);

    // 5: reset mid-BUSY at ch_idx=2, late done ignored, fresh latency
    do_reset();
    bus.period = 16'd10;
    bus.en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_nxt("t5_pre", 40);
      tk();
      bus.conv_done = 1'b1;
      tk();
      bus.conv_done = 1'b0;
    end
    wait_nxt("t5_third", 40);
    check_val("t5_ch2", int'(bus.ch_idx), 2);
    tk();
    rst = 1'b1;
    tk();
    rst = 1'b0;
    bus.en = 1'b0;
    bus.conv_done = 1'b1;
    #1;
    check_val("t5_fv_ign", int'(bus.frame_vld), 0);
    tk();
    bus.conv_done = 1'b0;
    check_val("t5_nxt",    int'(bus.nxt),         0);
    check_val("t5_busy",   int'(bus.busy),        0);
    check_val("t5_ch0",    int'(bus.ch_idx),      0);
    check_val("t5_err",    int'(bus.timeout_err), 0);
    check_val("t5_ovr",    int'(bus.overrun),     0);
    check_val("t5_tcnt",   int'(bus.tmo_cnt),     0);
    bus.en = 1'b1;
    t0 = cyc;
    wait_nxt("t5_restart", 40);
    check_val("t5_restart_lat", cyc - t0, 12);
    check_val("t5_restart_ch", int'(bus.ch_idx), 0);

    tk();
    check_val("double_nxt", dbl_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
